// File: rtl/su_adder_acc.sv
// Reduces PE-array psum vectors into runtime-shaped groups and read-modify-writes one GBF word per RF address.
// Latency: first write visible 3 cycles after the start edge; done pulse D+3 cycles after it; one write per cycle.
// Backpressure: none; the psum RFs and the GBF BRAM are assumed ready every cycle, starts are ignored while busy.
//
// Ports:
//   clk, reset (async, active-low)
//   psum_out          : ROW*COL signed psum lanes from the PE array, valid the cycle after psum_rf_addr
//   pe_psum_finish    : start request, only looked at while idle
//   conv_finish       : final-pass flag, latched at start, enables ReLU
//   irrel_num/rel_num : lanes per group / number of groups
//   rf_depth          : number of RF addresses to walk (1..2^PSUM_RF_ADDR_BITWIDTH)
//   base_addr         : first GBF word address (wraps modulo the BRAM depth)
//   acc_en / sat_en   : add prior GBF word / saturate instead of wrap
//   gbf_rd_data       : GBF read data, valid the cycle after psum_rd_en
//   psum_rf_addr      : RF read address while walking
//   psum_rd_en/addr   : GBF read strobe and address (accumulate mode only)
//   psum_write_en, psum_BRAM_addr, out_data : GBF write port
//   su_add_finish     : one-cycle done pulse
//   busy              : high from the first walk cycle through the done cycle
//   cfg_err           : one-cycle pulse when a start request carries an illegal config
module su_adder_acc #(
    parameter int ROW                   = 16,
    parameter int COL                   = 16,
    parameter int DATA_BITWIDTH         = 16,
    parameter int GBF_DATA_BITWIDTH     = 512,
    parameter int PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int GBF_ADDR_BITWIDTH     = 10
) (
    input  logic                                             clk,
    input  logic                                             reset,
    input  logic [DATA_BITWIDTH*ROW*COL-1:0]                 psum_out,
    input  logic                                             pe_psum_finish,
    input  logic                                             conv_finish,
    input  logic [$clog2(ROW*COL):0]                         irrel_num,
    input  logic [$clog2(GBF_DATA_BITWIDTH/DATA_BITWIDTH):0] rel_num,
    input  logic [PSUM_RF_ADDR_BITWIDTH:0]                   rf_depth,
    input  logic [GBF_ADDR_BITWIDTH-1:0]                     base_addr,
    input  logic                                             acc_en,
    input  logic                                             sat_en,
    input  logic [GBF_DATA_BITWIDTH-1:0]                     gbf_rd_data,
    output logic [PSUM_RF_ADDR_BITWIDTH-1:0]                 psum_rf_addr,
    output logic                                             psum_rd_en,
    output logic [GBF_ADDR_BITWIDTH-1:0]                     psum_rd_addr,
    output logic                                             psum_write_en,
    output logic [GBF_ADDR_BITWIDTH-1:0]                     psum_BRAM_addr,
    output logic [GBF_DATA_BITWIDTH-1:0]                     out_data,
    output logic                                             su_add_finish,
    output logic                                             busy,
    output logic                                             cfg_err
);

    localparam int LANES     = ROW * COL;
    localparam int DW        = DATA_BITWIDTH;
    localparam int OUT_LANES = GBF_DATA_BITWIDTH / DATA_BITWIDTH;
    localparam int SW        = DW + $clog2(LANES) + 1;   // full-width group sum
    localparam int AW        = GBF_ADDR_BITWIDTH;
    localparam int KW        = PSUM_RF_ADDR_BITWIDTH + 1;
    localparam int IW        = $clog2(LANES) + 1;
    localparam int RW        = $clog2(OUT_LANES) + 1;
    localparam int PIW       = $clog2(LANES + 1);        // prefix-sum index width
    localparam int MAX_DEPTH = 1 << PSUM_RF_ADDR_BITWIDTH;

    localparam logic [DW-1:0]        MAX_DW  = {1'b0, {(DW-1){1'b1}}};
    localparam logic [DW-1:0]        MIN_DW  = {1'b1, {(DW-1){1'b0}}};
    localparam logic signed [SW:0]   SAT_MAX = {{(SW+1-DW){1'b0}}, MAX_DW};
    localparam logic signed [SW:0]   SAT_MIN = {{(SW+1-DW){1'b1}}, MIN_DW};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [KW-1:0]   k, k_nxt;
    logic [1:0]      drain_cnt, drain_nxt;
    logic            cfg_ok;
    logic            start_req;

    // Config captured on the start edge; inputs are free to move afterwards.
    logic [IW-1:0]   irrel_q;
    logic [RW-1:0]   rel_q;
    logic [KW-1:0]   depth_q;
    logic [AW-1:0]   base_q;
    logic            acc_q;
    logic            sat_q;
    logic            relu_q;

    logic [AW-1:0]   cur_addr;

    // Pipeline: p1 marks the cycle whose psum_out/gbf_rd_data belong to index k,
    // s1 holds the registered group sums and GBF word.
    logic                      p1_vld;
    logic [AW-1:0]             p1_addr;
    logic                      s1_vld;
    logic [AW-1:0]             s1_addr;
    logic [OUT_LANES*SW-1:0]   s1_sum;
    logic [GBF_DATA_BITWIDTH-1:0] s1_gbf;

    logic [SW-1:0]             pre [LANES+1];
    logic [OUT_LANES*SW-1:0]   grp_sum;
    int                        lo_i;
    logic [PIW-1:0]            lo_idx;
    logic [PIW-1:0]            hi_idx;

    logic signed [SW:0]        acc_v;
    logic [DW-1:0]             lane_v;
    logic [GBF_DATA_BITWIDTH-1:0] out_word;

    // ------------------------------------------------------------------
    // Config legality and start detection
    // ------------------------------------------------------------------
    assign start_req = (state == S_IDLE) && pe_psum_finish;

    always_comb begin
        cfg_ok = 1'b1;
        if (irrel_num == '0)                              cfg_ok = 1'b0;
        if (rel_num == '0)                                cfg_ok = 1'b0;
        if (int'(rel_num) > OUT_LANES)                    cfg_ok = 1'b0;
        if (int'(irrel_num) * int'(rel_num) > LANES)      cfg_ok = 1'b0;
        if (rf_depth == '0)                               cfg_ok = 1'b0;
        if (int'(rf_depth) > MAX_DEPTH)                   cfg_ok = 1'b0;
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        k_nxt     = k;
        drain_nxt = drain_cnt;
        case (state)
            S_IDLE: begin
                k_nxt = '0;
                if (start_req && cfg_ok) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (k == depth_q - KW'(1)) begin
                    state_nxt = S_DRAIN;
                    drain_nxt = '0;
                end else begin
                    k_nxt = k + KW'(1);
                end
            end
            S_DRAIN: begin
                // Three cycles let the last index clear both pipeline stages.
                if (drain_cnt == 2'd2) state_nxt = S_DONE;
                else                   drain_nxt = drain_cnt + 2'd1;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            k         <= '0;
            drain_cnt <= '0;
            cfg_err   <= 1'b0;
            irrel_q   <= '0;
            rel_q     <= '0;
            depth_q   <= '0;
            base_q    <= '0;
            acc_q     <= 1'b0;
            sat_q     <= 1'b0;
            relu_q    <= 1'b0;
        end else begin
            state     <= state_nxt;
            k         <= k_nxt;
            drain_cnt <= drain_nxt;
            cfg_err   <= start_req && !cfg_ok;
            if (start_req && cfg_ok) begin
                irrel_q <= irrel_num;
                rel_q   <= rel_num;
                depth_q <= rf_depth;
                base_q  <= base_addr;
                acc_q   <= acc_en;
                sat_q   <= sat_en;
                relu_q  <= conv_finish;
            end
        end
    end

    assign cur_addr      = base_q + AW'(k);
    assign busy          = (state != S_IDLE);
    assign su_add_finish = (state == S_DONE);
    assign psum_rf_addr  = (state == S_RUN) ? k[PSUM_RF_ADDR_BITWIDTH-1:0] : '0;
    assign psum_rd_en    = (state == S_RUN) && acc_q;
    assign psum_rd_addr  = psum_rd_en ? cur_addr : '0;

    // ------------------------------------------------------------------
    // Group reduction via prefix sums: group g = pre[hi] - pre[lo].
    // Modular arithmetic is exact because every true group sum fits SW bits.
    // ------------------------------------------------------------------
    always_comb begin
        pre[0] = '0;
        for (int p = 0; p < LANES; p++) begin
            pre[p+1] = pre[p] + {{(SW-DW){psum_out[p*DW+DW-1]}}, psum_out[p*DW +: DW]};
        end
    end

    always_comb begin
        grp_sum = '0;
        lo_i    = 0;
        lo_idx  = '0;
        hi_idx  = '0;
        for (int g = 0; g < OUT_LANES; g++) begin
            lo_i   = g * int'(irrel_q);
            lo_idx = PIW'(lo_i);
            hi_idx = PIW'(lo_i + int'(irrel_q));
            // Legal configs keep hi_idx <= LANES for every active group.
            if (g < int'(rel_q)) begin
                grp_sum[g*SW +: SW] = pre[hi_idx] - pre[lo_idx];
            end
        end
    end

    // ------------------------------------------------------------------
    // Accumulate, narrow (saturate or wrap), ReLU, zero unused lanes
    // ------------------------------------------------------------------
    always_comb begin
        out_word = '0;
        acc_v    = '0;
        lane_v   = '0;
        for (int g = 0; g < OUT_LANES; g++) begin
            acc_v = {s1_sum[g*SW+SW-1], s1_sum[g*SW +: SW]}
                  + {{(SW+1-DW){s1_gbf[g*DW+DW-1]}}, s1_gbf[g*DW +: DW]};
            if (sat_q && (acc_v > SAT_MAX))      lane_v = MAX_DW;
            else if (sat_q && (acc_v < SAT_MIN)) lane_v = MIN_DW;
            else                                 lane_v = acc_v[DW-1:0];
            if (relu_q && lane_v[DW-1])          lane_v = '0;
            if (g < int'(rel_q))                 out_word[g*DW +: DW] = lane_v;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p1_vld         <= 1'b0;
            p1_addr        <= '0;
            s1_vld         <= 1'b0;
            s1_addr        <= '0;
            s1_sum         <= '0;
            s1_gbf         <= '0;
            psum_write_en  <= 1'b0;
            psum_BRAM_addr <= '0;
            out_data       <= '0;
        end else begin
            p1_vld  <= (state == S_RUN);
            p1_addr <= cur_addr;
            s1_vld  <= p1_vld;
            s1_addr <= p1_addr;
            if (p1_vld) begin
                s1_sum <= grp_sum;
                // Without accumulation the old word must not leak into the sum.
                s1_gbf <= acc_q ? gbf_rd_data : '0;
            end
            psum_write_en <= s1_vld;
            if (s1_vld) begin
                out_data       <= out_word;
                psum_BRAM_addr <= s1_addr;
            end
        end
    end

endmodule

// File: tb/tb_su_adder_acc.sv
module tb_su_adder_acc;

    localparam int ROW   = 16;
    localparam int COL   = 16;
    localparam int DW    = 16;
    localparam int GW    = 512;
    localparam int RFW   = 2;
    localparam int AW    = 10;
    localparam int LANES = ROW * COL;
    localparam int OL    = GW / DW;
    localparam int IRW   = $clog2(LANES) + 1;
    localparam int RLW   = $clog2(OL) + 1;
    localparam int DPW   = RFW + 1;
    localparam int GDEP  = 1 << AW;

    logic                clk = 1'b0;
    logic                reset;
    logic [DW*LANES-1:0] psum_out;
    logic                pe_psum_finish;
    logic                conv_finish;
    logic [IRW-1:0]      irrel_num;
    logic [RLW-1:0]      rel_num;
    logic [DPW-1:0]      rf_depth;
    logic [AW-1:0]       base_addr;
    logic                acc_en;
    logic                sat_en;
    logic [GW-1:0]       gbf_rd_data;
    logic [RFW-1:0]      psum_rf_addr;
    logic                psum_rd_en;
    logic [AW-1:0]       psum_rd_addr;
    logic                psum_write_en;
    logic [AW-1:0]       psum_BRAM_addr;
    logic [GW-1:0]       out_data;
    logic                su_add_finish;
    logic                busy;
    logic                cfg_err;

    su_adder_acc #(
        .ROW(ROW), .COL(COL), .DATA_BITWIDTH(DW), .GBF_DATA_BITWIDTH(GW),
        .PSUM_RF_ADDR_BITWIDTH(RFW), .GBF_ADDR_BITWIDTH(AW)
    ) dut (
        .clk(clk), .reset(reset), .psum_out(psum_out), .pe_psum_finish(pe_psum_finish),
        .conv_finish(conv_finish), .irrel_num(irrel_num), .rel_num(rel_num),
        .rf_depth(rf_depth), .base_addr(base_addr), .acc_en(acc_en), .sat_en(sat_en),
        .gbf_rd_data(gbf_rd_data), .psum_rf_addr(psum_rf_addr), .psum_rd_en(psum_rd_en),
        .psum_rd_addr(psum_rd_addr), .psum_write_en(psum_write_en),
        .psum_BRAM_addr(psum_BRAM_addr), .out_data(out_data),
        .su_add_finish(su_add_finish), .busy(busy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference storage: PE psum RFs and the psum GBF contents.
    logic [DW-1:0] psum_mem [4][LANES];
    logic [GW-1:0] gbf_mem  [GDEP];
    logic [GW-1:0] exp_w    [4];
    logic [AW-1:0] wr_addr_q [$];
    logic [GW-1:0] wr_data_q [$];

    task automatic check_val(input string tag, input logic [GW-1:0] got, input logic [GW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Spec-level model: direct per-group sums, then accumulate/narrow/ReLU.
    function automatic logic [GW-1:0] model_word(input int k, input int irr, input int rel,
                                                 input int base, input bit acc, input bit sat,
                                                 input bit relu);
        logic [GW-1:0] w;
        logic [GW-1:0] old;
        logic [DW-1:0] lane;
        int            s;
        w   = '0;
        old = gbf_mem[(base + k) % GDEP];
        for (int g = 0; g < rel; g++) begin
            s = 0;
            for (int i = 0; i < irr; i++) begin
                lane = psum_mem[k][g*irr + i];
                s += int'($signed(lane));
            end
            if (acc) begin
                lane = old[g*DW +: DW];
                s += int'($signed(lane));
            end
            if (sat) begin
                if (s > 32767) s = 32767;
                else if (s < -32768) s = -32768;
            end else begin
                s = int'(shortint'(s));
            end
            if (relu && s < 0) s = 0;
            w[g*DW +: DW] = s[DW-1:0];
        end
        return w;
    endfunction

    task automatic rand_gbf_data();
        for (int i = 0; i < GW/32; i++) gbf_rd_data[i*32 +: 32] = $urandom;
    endtask

    task automatic fill_psum_const(input logic [DW-1:0] v);
        for (int k = 0; k < 4; k++)
            for (int p = 0; p < LANES; p++) psum_mem[k][p] = v;
    endtask

    task automatic fill_psum_rand();
        for (int k = 0; k < 4; k++)
            for (int p = 0; p < LANES; p++) psum_mem[k][p] = 16'($urandom);
    endtask

    task automatic scramble_cfg();
        irrel_num   = IRW'($urandom);
        rel_num     = RLW'($urandom);
        rf_depth    = DPW'($urandom);
        base_addr   = AW'($urandom);
        acc_en      = 1'($urandom);
        sat_en      = 1'($urandom);
        conv_finish = 1'($urandom);
    endtask

    // Called at posedge+1 of an idle cycle; returns at posedge+1 of an idle cycle.
    task automatic run_pass(input int irr, input int rel, input int d, input int base,
                            input bit acc, input bit sat, input bit relu, input bit hold);
        logic [RFW-1:0] obs_rf;
        logic           obs_rd;
        logic [AW-1:0]  obs_ra;
        wr_addr_q.delete();
        wr_data_q.delete();
        for (int k = 0; k < d; k++) exp_w[k] = model_word(k, irr, rel, base, acc, sat, relu);
        irrel_num   = IRW'(irr);
        rel_num     = RLW'(rel);
        rf_depth    = DPW'(d);
        base_addr   = AW'(base);
        acc_en      = acc;
        sat_en      = sat;
        conv_finish = relu;
        pe_psum_finish = 1'b1;
        @(posedge clk); #1;
        if (!hold) pe_psum_finish = 1'b0;
        scramble_cfg();
        for (int n = 0; n <= d + 4; n++) begin
            @(negedge clk);
            check_val("busy", busy, n <= d + 3);
            check_val("finish", su_add_finish, n == d + 3);
            check_val("cfg_err", cfg_err, 1'b0);
            check_val("rd_en", psum_rd_en, acc && n < d);
            if (n < d) check_val("rf_addr", psum_rf_addr, n);
            if (n < d && acc) check_val("rd_addr", psum_rd_addr, (base + n) % GDEP);
            check_val("wr_en", psum_write_en, n >= 3 && n <= d + 2);
            if (n >= 3 && n <= d + 2) begin
                check_val("wr_addr", psum_BRAM_addr, (base + n - 3) % GDEP);
                check_val("wr_data", out_data, exp_w[n-3]);
            end
            if (psum_write_en) begin
                wr_addr_q.push_back(psum_BRAM_addr);
                wr_data_q.push_back(out_data);
            end
            obs_rf = psum_rf_addr;
            obs_rd = psum_rd_en;
            obs_ra = psum_rd_addr;
            @(posedge clk); #1;
            if (hold && n == d + 2) pe_psum_finish = 1'b0;
            // Synchronous-read RF and BRAM behaviour: data for the address seen last cycle.
            for (int p = 0; p < LANES; p++)
                psum_out[p*DW +: DW] = (n < d) ? psum_mem[obs_rf][p] : 16'($urandom);
            if (obs_rd) gbf_rd_data = gbf_mem[obs_ra];
            else        rand_gbf_data();
        end
        pe_psum_finish = 1'b0;
        for (int k = 0; k < d; k++) gbf_mem[(base + k) % GDEP] = exp_w[k];
    endtask

    task automatic illegal_pass(input int irr, input int rel, input int d);
        irrel_num      = IRW'(irr);
        rel_num        = RLW'(rel);
        rf_depth       = DPW'(d);
        base_addr      = AW'($urandom);
        acc_en         = 1'b1;
        pe_psum_finish = 1'b1;
        @(posedge clk); #1;
        pe_psum_finish = 1'b0;
        @(negedge clk);
        check_val("ill_cfg_err", cfg_err, 1'b1);
        check_val("ill_busy", busy, 1'b0);
        check_val("ill_wr_en", psum_write_en, 1'b0);
        check_val("ill_rd_en", psum_rd_en, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check_val("ill_cfg_err_pulse", cfg_err, 1'b0);
        check_val("ill_busy2", busy, 1'b0);
        check_val("ill_wr_en2", psum_write_en, 1'b0);
        @(posedge clk); #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [GW-1:0] w;
        logic [GW-1:0] e;
        int            irr, rel, d;

        reset = 1'b0;
        pe_psum_finish = 1'b0;
        psum_out = '0;
        gbf_rd_data = '0;
        scramble_cfg();
        for (int a = 0; a < GDEP; a++)
            for (int i = 0; i < GW/32; i++) gbf_mem[a][i*32 +: 32] = $urandom;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("rst_busy", busy, 1'b0);
        check_val("rst_finish", su_add_finish, 1'b0);
        check_val("rst_wr_en", psum_write_en, 1'b0);
        check_val("rst_out_data", out_data, '0);
        check_val("rst_bram_addr", psum_BRAM_addr, '0);
        check_val("rst_rd_en", psum_rd_en, 1'b0);
        check_val("rst_cfg_err", cfg_err, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;

        // Basic reduction: all ones, 3 groups of 4.
        fill_psum_const(16'h0001);
        run_pass(4, 3, 4, 'h010, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t1_nwr", wr_addr_q.size(), 4);
        e = '0;
        e[15:0] = 16'h0004; e[31:16] = 16'h0004; e[47:32] = 16'h0004;
        w = wr_data_q[0];
        check_val("t1_word0", w, e);
        w = wr_data_q[3];
        check_val("t1_word3", w, e);
        check_val("t1_last_addr", wr_addr_q[3], 10'h013);

        // Full rows: lane p = p, 16 groups of 16.
        for (int p = 0; p < LANES; p++) psum_mem[0][p] = 16'(p);
        run_pass(16, 16, 1, 'h020, 1'b0, 1'b0, 1'b0, 1'b0);
        check_val("t2_nwr", wr_addr_q.size(), 1);
        w = wr_data_q[0];
        check_val("t2_lane0", w[15:0], 16'h0078);
        check_val("t2_lane15", w[15*DW +: DW], 16'h0F78);
        check_val("t2_lane16", w[16*DW +: DW], 16'h0000);

        // Accumulate with saturation, then with wrap.
        fill_psum_const(16'h0010);
        for (int a = 'h100; a < 'h102; a++)
            for (int g = 0; g < OL; g++) gbf_mem[a][g*DW +: DW] = 16'h7FF0;
        run_pass(2, 32, 2, 'h100, 1'b1, 1'b1, 1'b0, 1'b0);
        w = wr_data_q[1];
        check_val("t3_sat_lane0", w[15:0], 16'h7FFF);
        check_val("t3_sat_lane31", w[31*DW +: DW], 16'h7FFF);
        for (int a = 'h100; a < 'h102; a++)
            for (int g = 0; g < OL; g++) gbf_mem[a][g*DW +: DW] = 16'h7FF0;
        run_pass(2, 32, 2, 'h100, 1'b1, 1'b0, 1'b0, 1'b0);
        w = wr_data_q[0];
        check_val("t3_wrap_lane0", w[15:0], 16'h8010);

        // ReLU and address wrap.
        fill_psum_const(16'hFFFF);
        run_pass(2, 4, 4, 'h3FE, 1'b0, 1'b0, 1'b1, 1'b0);
        check_val("t4_addr0", wr_addr_q[0], 10'h3FE);
        check_val("t4_addr1", wr_addr_q[1], 10'h3FF);
        check_val("t4_addr2", wr_addr_q[2], 10'h000);
        check_val("t4_addr3", wr_addr_q[3], 10'h001);
        w = wr_data_q[2];
        check_val("t4_relu_word", w, '0);

        // Illegal configurations.
        illegal_pass(1, 33, 1);
        illegal_pass(0, 3, 2);
        illegal_pass(3, 0, 2);
        illegal_pass(9, 30, 2);
        illegal_pass(1, 1, 0);
        illegal_pass(1, 1, 5);

        // Start held high through a whole pass must not retrigger.
        fill_psum_rand();
        run_pass(5, 7, 3, 'h200, 1'b1, 1'b1, 1'b0, 1'b1);

        // Reset in C_2 of a D=4 pass.
        fill_psum_rand();
        irrel_num = IRW'(4); rel_num = RLW'(8); rf_depth = DPW'(4);
        base_addr = AW'('h050); acc_en = 1'b1; sat_en = 1'b0; conv_finish = 1'b0;
        pe_psum_finish = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        check_val("rr_busy_pre", busy, 1'b1);
        check_val("rr_rf_pre", psum_rf_addr, 2);
        #1 reset = 1'b0;
        #1;
        check_val("rr_busy", busy, 1'b0);
        check_val("rr_rf", psum_rf_addr, '0);
        check_val("rr_rd_en", psum_rd_en, 1'b0);
        check_val("rr_rd_addr", psum_rd_addr, '0);
        check_val("rr_wr_en", psum_write_en, 1'b0);
        check_val("rr_bram_addr", psum_BRAM_addr, '0);
        check_val("rr_out_data", out_data, '0);
        check_val("rr_finish", su_add_finish, 1'b0);
        pe_psum_finish = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_val("rr_idle", busy, 1'b0);
        @(posedge clk); #1;
        run_pass(4, 8, 4, 'h050, 1'b1, 1'b0, 1'b0, 1'b0);

        // Randomized legal passes with occasional illegal requests.
        for (int t = 0; t < 24; t++) begin
            fill_psum_rand();
            d   = $urandom_range(1, 4);
            rel = $urandom_range(1, OL);
            irr = $urandom_range(1, LANES / rel);
            run_pass(irr, rel, d, $urandom_range(0, GDEP - 1), 1'($urandom), 1'($urandom),
                     1'($urandom), ($urandom_range(0, 3) == 0));
            if (t % 6 == 5) illegal_pass($urandom_range(1, 64), $urandom_range(33, 63), 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
